// File: rtl/cdb_pkg.sv
// Shared constants and types for the common data bus: source indices and bus widths.
package cdb_pkg;

    localparam int unsigned CDB_NSRC   = 4;
    localparam int unsigned CDB_ID_W   = 5;
    localparam int unsigned CDB_DATA_W = 32;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MUL = 2'd1,
        SRC_DIV = 2'd2,
        SRC_LSB = 2'd3
    } cdb_src_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: the first set request at or after ptr (wrapping) wins.
module rr_pick #(
    parameter int unsigned NSRC  = 4,
    parameter int unsigned PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NSRC-1:0]  gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any
);

    localparam int unsigned SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] sum;
    logic [PTR_W-1:0] idx;

    // Wrap by compare so non-power-of-2 source counts stay in range.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            sum = {1'b0, ptr} + SUM_W'(k);
            if (sum >= SUM_W'(NSRC)) begin
                sum = sum - SUM_W'(NSRC);
            end
            idx = sum[PTR_W-1:0];
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per execution unit, round-robin
// selection of one held result per cycle into a registered CDB broadcast.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned NSRC   = CDB_NSRC,
    parameter int unsigned ID_W   = CDB_ID_W,
    parameter int unsigned DATA_W = CDB_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hci_rdy,
    input  logic                     rob_rst,
    input  logic [NSRC-1:0]          src_valid,
    input  logic [NSRC*ID_W-1:0]     src_id,
    input  logic [NSRC*DATA_W-1:0]   src_val,
    output logic [NSRC-1:0]          src_ready,
    output logic                     cdb_en,
    output logic [ID_W-1:0]          cdb_id,
    output logic [DATA_W-1:0]        cdb_val,
    output logic [1:0]               cdb_src
);

    localparam int unsigned PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0]   hold_v_q,   hold_v_d;
    logic [ID_W-1:0]   hold_id_q   [NSRC];
    logic [ID_W-1:0]   hold_id_d   [NSRC];
    logic [DATA_W-1:0] hold_val_q  [NSRC];
    logic [DATA_W-1:0] hold_val_d  [NSRC];
    logic [PTR_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic              cdb_en_q,   cdb_en_d;
    logic [ID_W-1:0]   cdb_id_q,   cdb_id_d;
    logic [DATA_W-1:0] cdb_val_q,  cdb_val_d;
    logic [1:0]        cdb_src_q,  cdb_src_d;

    logic [NSRC-1:0]   gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_any;

    rr_pick #(
        .NSRC  (NSRC),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req     (hold_v_q),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    // A slot can accept a new result when empty or when it drains this cycle.
    assign src_ready = {NSRC{hci_rdy & ~rob_rst}} & (~hold_v_q | gnt);

    always_comb begin
        hold_v_d   = hold_v_q;
        hold_id_d  = hold_id_q;
        hold_val_d = hold_val_q;
        rr_ptr_d   = rr_ptr_q;
        cdb_en_d   = cdb_en_q;
        cdb_id_d   = cdb_id_q;
        cdb_val_d  = cdb_val_q;
        cdb_src_d  = cdb_src_q;

        if (hci_rdy) begin
            if (rob_rst) begin
                hold_v_d = '0;
                cdb_en_d = 1'b0;
                rr_ptr_d = '0;
            end else begin
                cdb_en_d = gnt_any;
                if (gnt_any) begin
                    cdb_id_d          = hold_id_q[gnt_idx];
                    cdb_val_d         = hold_val_q[gnt_idx];
                    cdb_src_d         = 2'(gnt_idx);
                    hold_v_d[gnt_idx] = 1'b0;
                    rr_ptr_d          = (gnt_idx == PTR_W'(NSRC - 1)) ? '0
                                                                      : gnt_idx + PTR_W'(1);
                end
                // Refill after the grant clear so a same-edge handover wins.
                for (int unsigned i = 0; i < NSRC; i++) begin
                    if (src_valid[i] && src_ready[i]) begin
                        hold_v_d[i]   = 1'b1;
                        hold_id_d[i]  = src_id[i*ID_W +: ID_W];
                        hold_val_d[i] = src_val[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v_q  <= '0;
            rr_ptr_q  <= '0;
            cdb_en_q  <= 1'b0;
            cdb_id_q  <= '0;
            cdb_val_q <= '0;
            cdb_src_q <= '0;
            for (int unsigned i = 0; i < NSRC; i++) begin
                hold_id_q[i]  <= '0;
                hold_val_q[i] <= '0;
            end
        end else begin
            hold_v_q   <= hold_v_d;
            hold_id_q  <= hold_id_d;
            hold_val_q <= hold_val_d;
            rr_ptr_q   <= rr_ptr_d;
            cdb_en_q   <= cdb_en_d;
            cdb_id_q   <= cdb_id_d;
            cdb_val_q  <= cdb_val_d;
            cdb_src_q  <= cdb_src_d;
        end
    end

    assign cdb_en  = cdb_en_q;
    assign cdb_id  = cdb_id_q;
    assign cdb_val = cdb_val_q;
    assign cdb_src = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-unit offer queues, a slot-level reference model, and a
// scoreboard that matches every CDB broadcast against the model's expected stream.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N  = 4;
    localparam int IW = 5;
    localparam int DW = 32;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] val;
    } item_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] val;
        logic [1:0]    src;
    } bc_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            hci_rdy;
    logic            rob_rst;
    logic [N-1:0]    src_valid;
    logic [N*IW-1:0] src_id;
    logic [N*DW-1:0] src_val;
    logic [N-1:0]    src_ready;
    logic            cdb_en;
    logic [IW-1:0]   cdb_id;
    logic [DW-1:0]   cdb_val;
    logic [1:0]      cdb_src;

    cdb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .hci_rdy   (hci_rdy),
        .rob_rst   (rob_rst),
        .src_valid (src_valid),
        .src_id    (src_id),
        .src_val   (src_val),
        .src_ready (src_ready),
        .cdb_en    (cdb_en),
        .cdb_id    (cdb_id),
        .cdb_val   (cdb_val),
        .cdb_src   (cdb_src)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    item_t pend [N][$];
    bc_t   sbq [$];
    bc_t   last_bc;

    // Reference model: one slot per unit plus a rotating start index.
    bit            m_full [N];
    item_t         m_slot [N];
    int            m_ptr;
    bit            exp_en;
    bit            ran;
    bit            in_rst;
    bit            xfer [N];

    function automatic int m_pick();
        for (int k = 0; k < N; k++) begin
            if (m_full[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int    g;
        bit    rdy [N];
        bc_t   b;
        for (int i = 0; i < N; i++) xfer[i] = 1'b0;
        if (rst) begin
            for (int i = 0; i < N; i++) m_full[i] = 1'b0;
            m_ptr  = 0;
            exp_en = 1'b0;
            ran    = 1'b0;
            in_rst = 1'b1;
        end else begin
            in_rst = 1'b0;
            ran    = hci_rdy;
            if (hci_rdy && rob_rst) begin
                for (int i = 0; i < N; i++) m_full[i] = 1'b0;
                m_ptr  = 0;
                exp_en = 1'b0;
            end else if (hci_rdy) begin
                g = m_pick();
                for (int i = 0; i < N; i++) rdy[i] = !m_full[i] || (i == g);
                if (g >= 0) begin
                    b.id  = m_slot[g].id;
                    b.val = m_slot[g].val;
                    b.src = 2'(g);
                    sbq.push_back(b);
                    m_full[g] = 1'b0;
                    m_ptr     = (g + 1) % N;
                    exp_en    = 1'b1;
                end else begin
                    exp_en = 1'b0;
                end
                for (int i = 0; i < N; i++) begin
                    if (src_valid[i] && rdy[i]) begin
                        m_full[i]     = 1'b1;
                        m_slot[i].id  = src_id[i*IW +: IW];
                        m_slot[i].val = src_val[i*DW +: DW];
                        xfer[i]       = 1'b1;
                    end
                end
            end
        end
    end

    // Output monitor: broadcasts are popped from the scoreboard; frozen cycles must hold.
    always @(posedge clk) begin
        bc_t e;
        #1;
        if (in_rst) begin
            last_bc = '{id: '0, val: '0, src: '0};
        end else begin
            total++;
            if (cdb_en !== exp_en) begin
                bad++;
                $display("FAIL cdb_en t=%0t got=%b want=%b", $time, cdb_en, exp_en);
            end
            if (ran && exp_en) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL sb_empty t=%0t got=broadcast want=none", $time);
                end else begin
                    e = sbq.pop_front();
                    last_bc = e;
                    if (cdb_id !== e.id || cdb_val !== e.val || cdb_src !== e.src) begin
                        bad++;
                        $display("FAIL bcast t=%0t got=%0d/%h/%0d want=%0d/%h/%0d",
                                 $time, cdb_id, cdb_val, cdb_src, e.id, e.val, e.src);
                    end
                end
            end else if (!ran) begin
                total++;
                if (cdb_id !== last_bc.id || cdb_val !== last_bc.val || cdb_src !== last_bc.src) begin
                    bad++;
                    $display("FAIL frozen t=%0t got=%0d/%h/%0d want=%0d/%h/%0d",
                             $time, cdb_id, cdb_val, cdb_src, last_bc.id, last_bc.val, last_bc.src);
                end
            end
        end
    end

    // Ready checker against the model's slot occupancy and pending grant.
    always @(negedge clk) begin
        logic [N-1:0] want;
        int g;
        #1;
        if (!rst) begin
            g = m_pick();
            for (int i = 0; i < N; i++)
                want[i] = hci_rdy && !rob_rst && (!m_full[i] || i == g);
            total++;
            if (src_ready !== want) begin
                bad++;
                $display("FAIL src_ready t=%0t got=%b want=%b", $time, src_ready, want);
            end
        end
    end

    task automatic offer(input int u, input logic [IW-1:0] id, input logic [DW-1:0] val);
        item_t it;
        it.id  = id;
        it.val = val;
        pend[u].push_back(it);
    endtask

    task automatic cycle(input logic h, input logic r);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (xfer[i] && pend[i].size() > 0) void'(pend[i].pop_front());
            xfer[i] = 1'b0;
        end
        hci_rdy = h;
        rob_rst = r;
        for (int i = 0; i < N; i++) begin
            src_valid[i] = pend[i].size() > 0;
            src_id[i*IW +: IW] = (pend[i].size() > 0) ? pend[i][0].id  : '0;
            src_val[i*DW +: DW] = (pend[i].size() > 0) ? pend[i][0].val : '0;
        end
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < N; i++) begin
            if (pend[i].size() > 0 || m_full[i]) return 1'b0;
        end
        return sbq.size() == 0;
    endfunction

    task automatic check_out(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        hci_rdy   = 1'b1;
        rob_rst   = 1'b0;
        src_valid = '0;
        src_id    = '0;
        src_val   = '0;
        repeat (3) cycle(1'b1, 1'b0);
        check_out("rst_en",  DW'(cdb_en),  '0);
        check_out("rst_id",  DW'(cdb_id),  '0);
        check_out("rst_val", cdb_val,      '0);
        check_out("rst_src", DW'(cdb_src), '0);
        rst = 1'b0;

        // Single ALU result.
        offer(int'(SRC_ALU), 5'd3, 32'hDEADBEEF);
        repeat (5) cycle(1'b1, 1'b0);

        // All four units in one cycle.
        for (int u = 0; u < N; u++) offer(u, 5'(u + 1), 32'h1000 + u);
        repeat (7) cycle(1'b1, 1'b0);

        // Streaming ALU against a single DIV result.
        offer(int'(SRC_DIV), 5'd9, 32'h99);
        for (int k = 0; k < 8; k++) begin
            offer(int'(SRC_ALU), 5'(5 + k), 32'hA000 + k);
            cycle(1'b1, 1'b0);
        end
        repeat (6) cycle(1'b1, 1'b0);

        // MUL second result while every slot is full.
        for (int u = 0; u < N; u++) offer(u, 5'(10 + u), 32'hB000 + u);
        offer(int'(SRC_MUL), 5'd20, 32'hB100);
        repeat (9) cycle(1'b1, 1'b0);

        // Flush with three entries held and all units offering.
        for (int u = 0; u < 3; u++) offer(u, 5'(21 + u), 32'hC000 + u);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        for (int u = 0; u < N; u++) offer(u, 5'(25 + u), 32'hC100 + u);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        repeat (8) cycle(1'b1, 1'b0);

        // Freeze with a flush request inside it.
        for (int u = 0; u < N; u++) offer(u, 5'(u), 32'hD000 + u);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        repeat (8) cycle(1'b1, 1'b0);

        // Randomized traffic with freezes and occasional flushes.
        for (int c = 0; c < 2000; c++) begin
            for (int u = 0; u < N; u++) begin
                if (pend[u].size() < 3 && $urandom_range(99) < 40)
                    offer(u, 5'($urandom), $urandom);
            end
            cycle(($urandom_range(99) < 85) ? 1'b1 : 1'b0,
                  ($urandom_range(99) < 4)  ? 1'b1 : 1'b0);
        end

        n = 0;
        while (!all_idle() && n < 200) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        cycle(1'b1, 1'b0);
        total++;
        if (!all_idle()) begin
            bad++;
            $display("FAIL drain got=busy want=idle sbq=%0d", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
